// File: rtl/data_mem_bridge.sv
// Memory-stage bridge to a word-addressed req/ack data bus.
// Stalls the pipeline while an access is outstanding; reports errors sticky.
module data_mem_bridge #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [3:0]       req_be,
  output logic             stall,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             err,
  output logic [CNT_W-1:0] txn_count,
  output logic             bus_req,
  output logic             bus_we,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wdata,
  output logic [3:0]       bus_be,
  input  logic             bus_ack,
  input  logic [31:0]      bus_rdata,
  input  logic             bus_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP,
    FAIL
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nx;
  logic [15:0] tmo;
  logic        aligned;
  logic        accept;

  assign aligned = (req_addr[1:0] == 2'b00);
  assign accept  = (state == IDLE) && req_valid && aligned;

  always_comb begin
    state_nx  = state;
    stall     = 1'b0;
    rsp_valid = 1'b0;
    bus_req   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (aligned) begin
            stall    = 1'b1;
            state_nx = BUS;
          end else begin
            state_nx = FAIL;
          end
        end
      end
      BUS: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        if (bus_ack) begin
          state_nx = bus_err ? FAIL : RESP;
        end else if (tmo == TMO_LAST) begin
          state_nx = FAIL;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nx  = IDLE;
      end
      FAIL: begin
        rsp_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tmo       <= '0;
      err       <= 1'b0;
      rsp_rdata <= '0;
      txn_count <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        bus_we    <= req_write;
        bus_addr  <= req_addr;
        bus_wdata <= req_write ? req_wdata : 32'h0;
        bus_be    <= req_write ? req_be : 4'hf;
        tmo       <= '0;
      end
      if (state == BUS && !bus_ack) begin
        tmo <= tmo + 16'd1;
      end
      if (state == BUS && bus_ack && !bus_err) begin
        rsp_rdata <= bus_we ? 32'h0 : bus_rdata;
      end
      // Any path into FAIL zeroes the response data it will present
      if (state_nx == FAIL) begin
        err       <= 1'b1;
        rsp_rdata <= '0;
      end
      if (state == RESP) begin
        txn_count <= txn_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Randomized bench for data_mem_bridge against a transaction-level model.
// Each access predicts bus residency, stall length, response data and flags.
module tb_data_mem_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        err;
  logic [31:0] txn_count;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic        m_err;
  logic [31:0] m_cnt;

  data_mem_bridge #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .err(err), .txn_count(txn_count),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts #1 after a rising edge; ends #1 after a rising edge in IDLE.
  task automatic access(input logic [31:0] a, input logic w,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int dly, input logic berr,
                        input logic [31:0] rd);
    logic        mis;
    logic        fail;
    int          exp_bus;
    logic [31:0] exp_rd;
    logic [31:0] exp_wd;
    logic [3:0]  exp_be;
    int          nbus;
    int          nstall;
    logic        done;
    mis    = (a[1:0] != 2'b00);
    exp_wd = w ? wd : 32'h0;
    exp_be = w ? be : 4'hf;
    if (mis) begin
      exp_bus = 0;
      fail    = 1'b1;
    end else if (dly < TO) begin
      exp_bus = dly + 1;
      fail    = berr;
    end else begin
      exp_bus = TO;
      fail    = 1'b1;
    end
    exp_rd = (fail || w) ? 32'h0 : rd;

    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    #1;
    chk("stall_first", {31'b0, stall}, {31'b0, !mis});
    chk("busreq_first", {31'b0, bus_req}, 32'd0);
    nbus   = 0;
    nstall = stall ? 1 : 0;
    done   = 1'b0;
    for (int c = 0; c < TO + 6 && !done; c++) begin
      @(posedge clk);
      #1;
      bus_ack   = 1'b0;
      bus_err   = 1'b0;
      bus_rdata = $urandom;
      if (rsp_valid) begin
        done = 1'b1;
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("stall_rsp", {31'b0, stall}, 32'd0);
        chk("busreq_rsp", {31'b0, bus_req}, 32'd0);
      end else begin
        if (bus_req) begin
          chk("bus_addr", bus_addr, a);
          chk("bus_we", {31'b0, bus_we}, {31'b0, w});
          chk("bus_wdata", bus_wdata, exp_wd);
          chk("bus_be", {28'b0, bus_be}, {28'b0, exp_be});
          if (nbus == dly) begin
            bus_ack   = 1'b1;
            bus_rdata = rd;
            bus_err   = berr;
          end
          nbus++;
        end
        if (stall) nstall++;
      end
    end
    chk("rsp_seen", {31'b0, done}, 32'd1);
    chk("bus_cycles", nbus, exp_bus);
    chk("stall_cycles", nstall, mis ? 0 : exp_bus + 1);
    req_valid = 1'b0;
    bus_ack   = 1'b0;
    m_err     = m_err | fail;
    if (!fail) m_cnt = m_cnt + 32'd1;
    @(posedge clk);
    #1;
    chk("err", {31'b0, err}, {31'b0, m_err});
    chk("txn_count", txn_count, m_cnt);
    chk("rsp_after", {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          dly;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    bus_err   = 1'b0;
    m_err     = 1'b0;
    m_cnt     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'b0, bus_we}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_be", {28'b0, bus_be}, 32'd0);
    chk("rst_txn", txn_count, 32'd0);
    rst = 1'b0;

    access(32'h2000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEEF);
    access(32'h2004, 1'b1, 32'h12345678, 4'b0011, 3, 1'b0, 32'hCAFEF00D);
    access(32'h2002, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h11111111);
    repeat (100) @(posedge clk);
    #1;
    chk("err_sticky", {31'b0, err}, 32'd1);
    access(32'h2008, 1'b0, 32'h0, 4'h0, TO + 5, 1'b0, 32'h22222222);
    access(32'h200C, 1'b0, 32'h0, 4'h0, 1, 1'b1, 32'h33333333);
    access(32'h2010, 1'b0, 32'h0, 4'h0, 2, 1'b0, 32'hA5A55A5A);

    // Reset during the second bus cycle of a load
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h2014;
    @(posedge clk);
    #1;
    chk("mid_busreq1", {31'b0, bus_req}, 32'd1);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_busreq", {31'b0, bus_req}, 32'd0);
    chk("mid_stall", {31'b0, stall}, 32'd0);
    chk("mid_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("mid_err", {31'b0, err}, 32'd0);
    chk("mid_txn", txn_count, 32'd0);
    // Request presented together with reset must not start an access
    req_valid = 1'b1;
    req_addr  = 32'h2018;
    @(posedge clk);
    #1;
    chk("rst_wins", {31'b0, bus_req}, 32'd0);
    req_valid = 1'b0;
    rst       = 1'b0;
    m_err     = 1'b0;
    m_cnt     = '0;
    access(32'h2018, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0BADF00D);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(3) == 0) begin
        bus_ack   = 1'b1;
        bus_rdata = $urandom;
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        chk("idle_ack_req", {31'b0, bus_req}, 32'd0);
        chk("idle_ack_rsp", {31'b0, rsp_valid}, 32'd0);
      end
      a = 32'h4000 + ($urandom_range(255) << 2);
      if ($urandom_range(7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      dly = ($urandom_range(5) == 0) ? $urandom_range(5, TO + 3)
                                     : $urandom_range(4);
      access(a, 1'($urandom_range(1)), $urandom, 4'($urandom_range(15)),
             dly, $urandom_range(7) == 0, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
